led_view_scheduler: RTL and testbench

LED_VIEW_SCHEDULER -- requirements
Module: led_view_scheduler

---
 rtl/led_view_scheduler.sv | 158 +++++++++++++++
 tb/tb_led_view_scheduler.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/led_view_scheduler.sv
// Chooses what the 8 LEDs show: the tick counter, tick+click sum, a held click
// count after each press, or an overflow blink when the click counter wraps.
module led_view_scheduler #(
  parameter int unsigned HOLD_TICKS  = 8,
  parameter int unsigned BLINK_TICKS = 6
) (
  input  logic       clock_divider_out,
  input  logic       reset,
  input  logic [7:0] tick_count,
  input  logic [7:0] click_count,
  input  logic       click_toggle,
  input  logic       mode_req,
  output logic [7:0] led_n,
  output logic [1:0] view,
  output logic       busy
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] BLINK_LOAD = CNT_W'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    ST_BASE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_BLINK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;
  logic             base_mode_q, base_mode_d;
  logic [1:0]       arm_q;
  logic             click_s1_q, click_s2_q, click_prev_q;
  logic             mode_s1_q, mode_s2_q, mode_prev_q;

  logic armed;
  logic click_ev;
  logic mode_ev;
  logic [7:0] disp;

  // Events stay masked for the first three edges after reset so that
  // synchronizer flops filling up from 0 cannot fake a press.
  assign armed    = (arm_q == 2'd3);
  assign click_ev = armed & (click_s2_q ^ click_prev_q);
  assign mode_ev  = armed & mode_s2_q & ~mode_prev_q;

  // State register, synchronizers and arm counter
  always_ff @(posedge clock_divider_out or posedge reset) begin
    if (reset) begin
      state_q      <= ST_BASE;
      hold_cnt_q   <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      base_mode_q  <= 1'b0;
      arm_q        <= 2'd0;
      click_s1_q   <= 1'b0;
      click_s2_q   <= 1'b0;
      click_prev_q <= 1'b0;
      mode_s1_q    <= 1'b0;
      mode_s2_q    <= 1'b0;
      mode_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      base_mode_q  <= base_mode_d;
      if (!armed) arm_q <= arm_q + 2'd1;
      click_s1_q   <= click_toggle;
      click_s2_q   <= click_s1_q;
      click_prev_q <= click_s2_q;
      mode_s1_q    <= mode_req;
      mode_s2_q    <= mode_s1_q;
      mode_prev_q  <= mode_s2_q;
    end
  end

  // Next-state logic; a wrapped click counter (0) always wins over a hold
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    base_mode_d = base_mode_q ^ mode_ev;
    case (state_q)
      ST_BASE: begin
        if (click_ev) begin
          if (click_count != 8'd0) begin
            state_d    = ST_HOLD;
            hold_cnt_d = HOLD_LOAD;
          end else begin
            state_d     = ST_BLINK;
            blink_cnt_d = BLINK_LOAD;
            phase_d     = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (click_ev) begin
          if (click_count != 8'd0) begin
            hold_cnt_d = HOLD_LOAD;
          end else begin
            state_d     = ST_BLINK;
            blink_cnt_d = BLINK_LOAD;
            phase_d     = 1'b1;
          end
        end else if (hold_cnt_q == '0) begin
          state_d = ST_BASE;
        end else begin
          hold_cnt_d = hold_cnt_q - CNT_W'(1);
        end
      end
      ST_BLINK: begin
        phase_d = ~phase_q;
        if (blink_cnt_q == '0) begin
          state_d = ST_BASE;
        end else begin
          blink_cnt_d = blink_cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_BASE;
    endcase
  end

  // Display path is combinational so live counters show without extra lag
  always_comb begin
    disp = tick_count;
    view = 2'b00;
    case (state_q)
      ST_BASE: begin
        if (base_mode_q) begin
          disp = tick_count + click_count;
          view = 2'b01;
        end else begin
          disp = tick_count;
          view = 2'b00;
        end
      end
      ST_HOLD: begin
        disp = click_count;
        view = 2'b10;
      end
      ST_BLINK: begin
        disp = phase_q ? 8'hFF : 8'h00;
        view = 2'b11;
      end
      default: begin
        disp = tick_count;
        view = 2'b00;
      end
    endcase
  end

  assign led_n = ~disp;
  assign busy  = (state_q != ST_BASE);

endmodule

// File: tb/tb_led_view_scheduler.sv
// Directed bench for led_view_scheduler: expected outputs are queued per step
// and popped against the DUT one time unit after each rising edge.
module tb_led_view_scheduler;

  logic       clk;
  logic       reset;
  logic [7:0] tick_count;
  logic [7:0] click_count;
  logic       click_toggle;
  logic       mode_req;
  logic [7:0] led_n;
  logic [1:0] view;
  logic       busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [7:0] led;
    logic [1:0] view;
    logic       busy;
  } exp_t;

  exp_t sb[$];

  led_view_scheduler #(.HOLD_TICKS(8), .BLINK_TICKS(6)) dut (
    .clock_divider_out (clk),
    .reset             (reset),
    .tick_count        (tick_count),
    .click_count       (click_count),
    .click_toggle      (click_toggle),
    .mode_req          (mode_req),
    .led_n             (led_n),
    .view              (view),
    .busy              (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push(input string tag, input logic [7:0] led, input logic [1:0] v, input logic b);
    exp_t e;
    e.tag  = tag;
    e.led  = led;
    e.view = v;
    e.busy = b;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL sb_empty: no expected entry queued");
    end else begin
      e = sb.pop_front();
      assert (led_n === e.led && view === e.view && busy === e.busy) else begin
        bad++;
        $error("FAIL %s: led_n=%h view=%b busy=%b, expected led_n=%h view=%b busy=%b",
               e.tag, led_n, view, busy, e.led, e.view, e.busy);
      end
    end
  endtask

  // Compare without waiting for a clock edge
  task automatic expect_now(input string tag, input logic [7:0] led, input logic [1:0] v, input logic b);
    push(tag, led, v, b);
    pop_check();
  endtask

  // Advance one rising edge, then compare
  task automatic expect_edge(input string tag, input logic [7:0] led, input logic [1:0] v, input logic b);
    push(tag, led, v, b);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    reset        = 1'b0;
    click_toggle = 1'b1;
    mode_req     = 1'b0;
    tick_count   = 8'h05;
    click_count  = 8'h00;
    #1 reset = 1'b1;
    #2 expect_now("reset_state", 8'hFA, 2'b00, 1'b0);
    expect_edge("in_reset", 8'hFA, 2'b00, 1'b0);
    expect_edge("in_reset", 8'hFA, 2'b00, 1'b0);

    // Release with click_toggle held high: no click may be seen
    reset = 1'b0;
    for (int i = 0; i < 10; i++) expect_edge("release_no_click", 8'hFA, 2'b00, 1'b0);

    // Single click with count 3: two-edge latency then 8 HOLD edges
    click_count  = 8'h03;
    click_toggle = 1'b0;
    expect_edge("click_lat", 8'hFA, 2'b00, 1'b0);
    expect_edge("click_lat", 8'hFA, 2'b00, 1'b0);
    for (int i = 0; i < 8; i++) expect_edge("hold", 8'hFC, 2'b10, 1'b1);
    expect_edge("hold_exit", 8'hFA, 2'b00, 1'b0);

    // Second click lands on the 5th HOLD edge and reloads the hold
    click_toggle = 1'b1;
    expect_edge("ext_lat", 8'hFA, 2'b00, 1'b0);
    expect_edge("ext_lat", 8'hFA, 2'b00, 1'b0);
    expect_edge("ext_hold", 8'hFC, 2'b10, 1'b1);
    expect_edge("ext_hold", 8'hFC, 2'b10, 1'b1);
    click_toggle = 1'b0;
    for (int i = 0; i < 10; i++) expect_edge("ext_hold", 8'hFC, 2'b10, 1'b1);
    expect_edge("ext_exit", 8'hFA, 2'b00, 1'b0);

    // Wrapped counter: 6-edge blink starting lit; a click mid-blink is ignored
    click_count  = 8'h00;
    click_toggle = 1'b1;
    expect_edge("blink_lat", 8'hFA, 2'b00, 1'b0);
    expect_edge("blink_lat", 8'hFA, 2'b00, 1'b0);
    expect_edge("blink1", 8'h00, 2'b11, 1'b1);
    expect_edge("blink2", 8'hFF, 2'b11, 1'b1);
    click_count  = 8'h03;
    click_toggle = 1'b0;
    expect_edge("blink3", 8'h00, 2'b11, 1'b1);
    expect_edge("blink4", 8'hFF, 2'b11, 1'b1);
    expect_edge("blink5", 8'h00, 2'b11, 1'b1);
    expect_edge("blink6", 8'hFF, 2'b11, 1'b1);
    for (int i = 0; i < 3; i++) expect_edge("blink_exit", 8'hFA, 2'b00, 1'b0);

    // Mode pulse: SUM view shows (F0 + 20) mod 256 = 10
    tick_count  = 8'hF0;
    click_count = 8'h20;
    mode_req    = 1'b1;
    expect_edge("mode_lat", 8'h0F, 2'b00, 1'b0);
    expect_edge("mode_lat", 8'h0F, 2'b00, 1'b0);
    expect_edge("sum_view", 8'hEF, 2'b01, 1'b0);
    mode_req = 1'b0;
    expect_edge("sum_view", 8'hEF, 2'b01, 1'b0);
    expect_edge("sum_view", 8'hEF, 2'b01, 1'b0);

    // Mode and click together: HOLD, then back to TICK view
    mode_req     = 1'b1;
    click_toggle = 1'b1;
    expect_edge("co_lat", 8'hEF, 2'b01, 1'b0);
    expect_edge("co_lat", 8'hEF, 2'b01, 1'b0);
    for (int i = 0; i < 8; i++) expect_edge("co_hold", 8'hDF, 2'b10, 1'b1);
    mode_req = 1'b0;
    expect_edge("co_exit_tick", 8'h0F, 2'b00, 1'b0);
    expect_edge("co_exit_tick", 8'h0F, 2'b00, 1'b0);

    // Asynchronous reset at the 3rd blink edge
    click_count  = 8'h00;
    click_toggle = 1'b0;
    expect_edge("b2_lat", 8'h0F, 2'b00, 1'b0);
    expect_edge("b2_lat", 8'h0F, 2'b00, 1'b0);
    expect_edge("b2_blink1", 8'h00, 2'b11, 1'b1);
    expect_edge("b2_blink2", 8'hFF, 2'b11, 1'b1);
    expect_edge("b2_blink3", 8'h00, 2'b11, 1'b1);
    #2 reset = 1'b1;
    #1 expect_now("async_reset", 8'h0F, 2'b00, 1'b0);
    expect_edge("in_reset2", 8'h0F, 2'b00, 1'b0);
    expect_edge("in_reset2", 8'h0F, 2'b00, 1'b0);

    // Toggle at release must stay masked until arm saturates
    reset        = 1'b0;
    click_count  = 8'h03;
    click_toggle = 1'b1;
    for (int i = 0; i < 6; i++) expect_edge("rearm_masked", 8'h0F, 2'b00, 1'b0);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_leftover: entries=%0d, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
